// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Function : In-order retirement buffer for out-of-order completions, with
//            store hand-off and mispredict flush at retire.
// Revision : 1.0
// ============================================================================
module reorder_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PHY_WIDTH  = 6,
    parameter int ROB_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic [PHY_WIDTH-1:0]  alloc_rd_phy,
    input  logic [PHY_WIDTH-1:0]  alloc_old_phy,
    output logic                  alloc_ready,
    output logic [ROB_WIDTH-1:0]  alloc_rob_id,
    input  logic                  commit_alu_valid,
    input  logic [ROB_WIDTH-1:0]  commit_alu_rob_id,
    input  logic [1:0]            commit_ls_valid,
    input  logic [ROB_WIDTH-1:0]  commit_ls_rob_id,
    input  logic [DATA_WIDTH-1:0] commit_wdata,
    input  logic [ADDR_WIDTH-1:0] commit_waddr,
    input  logic                  commit_branch_valid,
    input  logic                  commit_jump_valid,
    input  logic [ROB_WIDTH-1:0]  commit_branch_rob_id,
    input  logic                  commit_mispredict,
    input  logic                  commit_actual_taken,
    input  logic [ADDR_WIDTH-1:0] commit_actual_target,
    input  logic [ADDR_WIDTH-1:0] commit_nextPC,
    output logic                  retire_valid,
    output logic [ROB_WIDTH-1:0]  retire_rob_id,
    output logic [PHY_WIDTH-1:0]  retire_old_phy,
    output logic                  retire_store_valid,
    output logic [ADDR_WIDTH-1:0] retire_waddr,
    output logic [DATA_WIDTH-1:0] retire_wdata,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int                   c_DEPTH   = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0]   c_FULL    = (ROB_WIDTH+1)'(c_DEPTH);
    localparam logic [ROB_WIDTH:0]   c_CNT_ONE = 1;
    localparam logic [ROB_WIDTH-1:0] c_PTR_ONE = 1;
    localparam logic [c_DEPTH-1:0]   c_ONE     = 1;

    logic [c_DEPTH-1:0]    r_valid, r_done, r_is_store, r_mispred;
    logic [PHY_WIDTH-1:0]  r_rd_phy  [c_DEPTH];
    logic [PHY_WIDTH-1:0]  r_old_phy [c_DEPTH];
    logic [ADDR_WIDTH-1:0] r_waddr   [c_DEPTH];
    logic [ADDR_WIDTH-1:0] r_target  [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_wdata   [c_DEPTH];
    logic [ROB_WIDTH-1:0]  r_head, r_tail;
    logic [ROB_WIDTH:0]    r_count;

    logic                  r_retire_valid, r_retire_store_valid, r_flush;
    logic [ROB_WIDTH-1:0]  r_retire_rob_id;
    logic [PHY_WIDTH-1:0]  r_retire_old_phy;
    logic [ADDR_WIDTH-1:0] r_retire_waddr, r_redirect_pc;
    logic [DATA_WIDTH-1:0] r_retire_wdata;

    logic                  w_alloc_ready, w_alloc, w_retire, w_flush_now, w_br_valid;
    logic [ADDR_WIDTH-1:0] w_br_target;
    logic [c_DEPTH-1:0]    w_alloc_sel, w_ret_sel, w_cmp_gate;
    logic [c_DEPTH-1:0]    w_done_sel, w_st_sel, w_br_sel;
    logic                  w_unused_rd_phy;

    assign w_alloc_ready = (r_count < c_FULL) && !r_flush;
    assign w_alloc       = alloc_valid && w_alloc_ready;
    assign w_retire      = r_valid[r_head] && r_done[r_head];
    assign w_flush_now   = w_retire && r_mispred[r_head];
    assign w_br_valid    = commit_branch_valid || commit_jump_valid;
    assign w_br_target   = commit_actual_taken ? commit_actual_target : commit_nextPC;

    // Completions only land on live entries, and never during the flush cycle.
    assign w_cmp_gate  = r_flush ? '0 : r_valid;
    assign w_alloc_sel = w_alloc  ? (c_ONE << r_tail) : '0;
    assign w_ret_sel   = w_retire ? (c_ONE << r_head) : '0;
    assign w_st_sel    = (commit_ls_valid[1] ? (c_ONE << commit_ls_rob_id) : '0) & w_cmp_gate;
    assign w_br_sel    = (w_br_valid ? (c_ONE << commit_branch_rob_id) : '0) & w_cmp_gate;
    assign w_done_sel  = ((commit_alu_valid ? (c_ONE << commit_alu_rob_id) : '0)
                        | ((|commit_ls_valid) ? (c_ONE << commit_ls_rob_id) : '0)
                        | w_br_sel) & w_cmp_gate;

    // rd_phy is held per entry for debug visibility; no retire path reads it.
    assign w_unused_rd_phy = ^r_rd_phy[r_head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= '0;
            r_done     <= '0;
            r_is_store <= '0;
            r_mispred  <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (w_flush_now) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_valid    <= (r_valid | w_alloc_sel) & ~w_ret_sel;
            r_done     <= (r_done & ~w_alloc_sel) | w_done_sel;
            r_is_store <= (r_is_store & ~w_alloc_sel) | w_st_sel;
            r_mispred  <= (r_mispred & ~w_alloc_sel & ~w_br_sel)
                        | (w_br_sel & {c_DEPTH{commit_mispredict}});
            if (w_alloc)  r_tail <= r_tail + c_PTR_ONE;
            if (w_retire) r_head <= r_head + c_PTR_ONE;
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_DEPTH; i++) begin
            if (w_alloc_sel[i]) begin
                r_rd_phy[i]  <= alloc_rd_phy;
                r_old_phy[i] <= alloc_old_phy;
            end
            if (w_st_sel[i]) begin
                r_waddr[i] <= commit_waddr;
                r_wdata[i] <= commit_wdata;
            end
            if (w_br_sel[i]) r_target[i] <= w_br_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_valid       <= 1'b0;
            r_retire_store_valid <= 1'b0;
            r_flush              <= 1'b0;
            r_retire_rob_id      <= '0;
            r_retire_old_phy     <= '0;
            r_retire_waddr       <= '0;
            r_retire_wdata       <= '0;
            r_redirect_pc        <= '0;
        end else begin
            r_retire_valid       <= w_retire;
            r_retire_store_valid <= w_retire && r_is_store[r_head];
            r_flush              <= w_flush_now;
            if (w_retire) begin
                r_retire_rob_id  <= r_head;
                r_retire_old_phy <= r_old_phy[r_head];
                r_retire_waddr   <= r_waddr[r_head];
                r_retire_wdata   <= r_wdata[r_head];
            end
            if (w_flush_now) r_redirect_pc <= r_target[r_head];
        end
    end

    assign alloc_ready        = w_alloc_ready;
    assign alloc_rob_id       = r_tail;
    assign retire_valid       = r_retire_valid;
    assign retire_rob_id      = r_retire_rob_id;
    assign retire_old_phy     = r_retire_old_phy;
    assign retire_store_valid = r_retire_store_valid;
    assign retire_waddr       = r_retire_waddr;
    assign retire_wdata       = r_retire_wdata;
    assign flush              = r_flush;
    assign redirect_pc        = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Function : Directed and random stimulus for reorder_buffer, checked against
//            a queue-based program-order model.
// Revision : 1.0
// ============================================================================
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid;
    logic [5:0]  alloc_rd_phy, alloc_old_phy;
    logic        alloc_ready;
    logic [4:0]  alloc_rob_id;
    logic        commit_alu_valid;
    logic [4:0]  commit_alu_rob_id;
    logic [1:0]  commit_ls_valid;
    logic [4:0]  commit_ls_rob_id;
    logic [31:0] commit_wdata, commit_waddr;
    logic        commit_branch_valid, commit_jump_valid;
    logic [4:0]  commit_branch_rob_id;
    logic        commit_mispredict, commit_actual_taken;
    logic [31:0] commit_actual_target, commit_nextPC;
    logic        retire_valid;
    logic [4:0]  retire_rob_id;
    logic [5:0]  retire_old_phy;
    logic        retire_store_valid;
    logic [31:0] retire_waddr, retire_wdata;
    logic        flush;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd_phy(alloc_rd_phy), .alloc_old_phy(alloc_old_phy),
        .alloc_ready(alloc_ready), .alloc_rob_id(alloc_rob_id),
        .commit_alu_valid(commit_alu_valid), .commit_alu_rob_id(commit_alu_rob_id),
        .commit_ls_valid(commit_ls_valid), .commit_ls_rob_id(commit_ls_rob_id),
        .commit_wdata(commit_wdata), .commit_waddr(commit_waddr),
        .commit_branch_valid(commit_branch_valid), .commit_jump_valid(commit_jump_valid),
        .commit_branch_rob_id(commit_branch_rob_id), .commit_mispredict(commit_mispredict),
        .commit_actual_taken(commit_actual_taken), .commit_actual_target(commit_actual_target),
        .commit_nextPC(commit_nextPC),
        .retire_valid(retire_valid), .retire_rob_id(retire_rob_id), .retire_old_phy(retire_old_phy),
        .retire_store_valid(retire_store_valid), .retire_waddr(retire_waddr),
        .retire_wdata(retire_wdata), .flush(flush), .redirect_pc(redirect_pc)
    );

    typedef struct {
        int          id;
        logic [5:0]  old_phy;
        bit          done;
        bit          st;
        logic [31:0] wa;
        logic [31:0] wd;
        bit          mp;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];
    int   m_tail  = 0;
    bit   m_flush = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        alloc_valid = 0; alloc_rd_phy = 0; alloc_old_phy = 0;
        commit_alu_valid = 0; commit_alu_rob_id = 0;
        commit_ls_valid = 0; commit_ls_rob_id = 0; commit_wdata = 0; commit_waddr = 0;
        commit_branch_valid = 0; commit_jump_valid = 0; commit_branch_rob_id = 0;
        commit_mispredict = 0; commit_actual_taken = 0;
        commit_actual_target = 0; commit_nextPC = 0;
    endtask

    // One clock: check allocation view, advance model, clock, check retire view.
    task automatic cyc();
        bit   ready, do_alloc, do_ret, fl;
        ent_t r, e;
        ready = (q.size() < 32) && !m_flush;
        chk("alloc_ready", alloc_ready, ready);
        chk("alloc_rob_id", alloc_rob_id, m_tail);
        do_alloc = alloc_valid && ready;
        do_ret   = (q.size() > 0) && q[0].done;
        r = '{default: 0};
        if (do_ret) r = q[0];
        if (!m_flush) begin
            foreach (q[k]) begin
                if (commit_alu_valid && q[k].id == commit_alu_rob_id) q[k].done = 1;
                if (commit_ls_valid[0] && q[k].id == commit_ls_rob_id) q[k].done = 1;
                if (commit_ls_valid[1] && q[k].id == commit_ls_rob_id) begin
                    q[k].done = 1; q[k].st = 1; q[k].wa = commit_waddr; q[k].wd = commit_wdata;
                end
                if ((commit_branch_valid || commit_jump_valid) && q[k].id == commit_branch_rob_id) begin
                    q[k].done = 1;
                    q[k].mp   = commit_mispredict;
                    q[k].tgt  = commit_actual_taken ? commit_actual_target : commit_nextPC;
                end
            end
        end
        if (do_ret) void'(q.pop_front());
        fl = do_ret && r.mp;
        if (fl) begin
            q.delete();
            m_tail = 0;
        end else if (do_alloc) begin
            e = '{default: 0};
            e.id = m_tail; e.old_phy = alloc_old_phy;
            q.push_back(e);
            m_tail = (m_tail + 1) % 32;
        end
        m_flush = fl;
        @(posedge clk); #1;
        chk("retire_valid", retire_valid, do_ret);
        chk("retire_store_valid", retire_store_valid, do_ret && r.st);
        chk("flush", flush, fl);
        if (do_ret) begin
            chk("retire_rob_id", retire_rob_id, r.id);
            chk("retire_old_phy", retire_old_phy, r.old_phy);
        end
        if (do_ret && r.st) begin
            chk("retire_waddr", retire_waddr, r.wa);
            chk("retire_wdata", retire_wdata, r.wd);
        end
        if (fl) chk("redirect_pc", redirect_pc, r.tgt);
        clr_in();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_retire_valid", retire_valid, 0);
        chk("rst_retire_store_valid", retire_store_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_retire_rob_id", retire_rob_id, 0);
        chk("rst_retire_old_phy", retire_old_phy, 0);
        chk("rst_retire_waddr", retire_waddr, 0);
        chk("rst_retire_wdata", retire_wdata, 0);
        chk("rst_alloc_rob_id", alloc_rob_id, 0);
    endtask

    // Asserts reset mid-cycle, away from the clock edge.
    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        q.delete(); m_tail = 0; m_flush = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic alloc_n(input int n);
        repeat (n) begin
            alloc_valid   = 1;
            alloc_old_phy = 6'($urandom);
            alloc_rd_phy  = 6'($urandom);
            cyc();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    function automatic int pick_id();
        if (q.size() > 0 && ($urandom % 4) != 0) return q[$urandom % q.size()].id;
        return int'($urandom % 32);
    endfunction

    function automatic bit not_done(input int id);
        foreach (q[k]) if (q[k].id == id && q[k].done) return 0;
        return 1;
    endfunction

    task automatic rnd_stim();
        int a, l, b;
        alloc_valid   = ($urandom % 4) != 0;
        alloc_old_phy = 6'($urandom);
        alloc_rd_phy  = 6'($urandom);
        a = pick_id(); l = pick_id(); b = pick_id();
        if (($urandom % 2) == 1 && not_done(a)) begin
            commit_alu_valid = 1; commit_alu_rob_id = 5'(a);
        end
        if (($urandom % 2) == 1 && not_done(l) && !(commit_alu_valid && l == a)) begin
            commit_ls_valid  = 2'($urandom_range(1, 3));
            commit_ls_rob_id = 5'(l);
            commit_waddr     = $urandom;
            commit_wdata     = $urandom;
        end
        if (($urandom % 2) == 1 && not_done(b) && !(commit_alu_valid && b == a)
            && !(commit_ls_valid != 0 && b == l)) begin
            if (($urandom % 2) == 1) begin
                commit_branch_valid = 1;
                commit_mispredict   = ($urandom % 8) == 0;
            end else begin
                commit_jump_valid = 1;
            end
            commit_branch_rob_id = 5'(b);
            commit_actual_taken  = 1'($urandom);
            commit_actual_target = $urandom;
            commit_nextPC        = $urandom;
        end
    endtask

    initial begin
        clr_in();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Out-of-order ALU completion, in-order retirement
        alloc_n(3);
        idle(1);
        commit_alu_valid = 1; commit_alu_rob_id = 2; cyc();
        commit_alu_valid = 1; commit_alu_rob_id = 0; cyc();
        commit_alu_valid = 1; commit_alu_rob_id = 1; cyc();
        idle(4);

        // Store retirement
        do_reset();
        alloc_n(1);
        commit_ls_valid = 2'b10; commit_ls_rob_id = 0;
        commit_waddr = 32'h100; commit_wdata = 32'hDEADBEEF;
        cyc();
        idle(3);

        // Mispredict at id1 flushes younger ids 2-4
        do_reset();
        alloc_n(5);
        commit_alu_valid = 1; commit_alu_rob_id = 0;
        commit_ls_valid = 2'b01; commit_ls_rob_id = 2;
        commit_branch_valid = 1; commit_branch_rob_id = 1; commit_mispredict = 1;
        commit_actual_taken = 1; commit_actual_target = 32'h2000; commit_nextPC = 32'h1004;
        cyc();
        commit_alu_valid = 1; commit_alu_rob_id = 3;
        commit_ls_valid = 2'b01; commit_ls_rob_id = 4;
        cyc();
        idle(4);
        alloc_n(2);
        idle(2);

        // Three completion sources in one cycle
        do_reset();
        alloc_n(3);
        commit_alu_valid = 1; commit_alu_rob_id = 0;
        commit_ls_valid = 2'b01; commit_ls_rob_id = 1;
        commit_jump_valid = 1; commit_branch_rob_id = 2; commit_nextPC = 32'h44;
        cyc();
        idle(5);

        // Full buffer, retire with blocked allocation, tail wrap
        do_reset();
        alloc_n(32);
        alloc_valid = 1; cyc();
        alloc_valid = 1; commit_alu_valid = 1; commit_alu_rob_id = 0; cyc();
        alloc_valid = 1; cyc();
        alloc_valid = 1; cyc();
        idle(2);

        // Reset with entries pending
        do_reset();
        alloc_n(5);
        commit_alu_valid = 1; commit_alu_rob_id = 0; cyc();
        do_reset();
        idle(1);

        // Random traffic
        do_reset();
        repeat (3000) begin
            rnd_stim();
            cyc();
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
